// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, NOP encoding and instruction field positions.
package cpu_pkg;

  typedef enum logic [1:0] {FETCH, WAIT, DISCARD, HOLD} fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory read port: one-cycle request, single delayed response per request.
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input rvalid, rdata);
  modport slave  (input req, addr, output rvalid, rdata);
endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble is inserted.
module ifid_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o
);
  import cpu_pkg::*;

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (flush_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      pc4_d   = 32'h0;
    end else if (!stall_i) begin
      if (load_i) begin
        valid_d = 1'b1;
        instr_d = instr_i;
        pc4_d   = pc4_i;
      end else begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
        pc4_d   = 32'h0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: pc, request FSM with one outstanding read, skid buffer for stalled
// responses, and the IF/ID register feeding decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_stage_if.master        imem,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 redirect_valid_i,
  input  logic [31:0]          redirect_pc_i,
  output logic                 ifid_valid_o,
  output logic [31:0]          ifid_instr_o,
  output logic [31:0]          ifid_pc4_o,
  output logic [5:0]           opcode_o,
  output logic [5:0]           funct_o
);
  import cpu_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic         skid_valid_q, skid_valid_d;
  logic [31:0]  skid_instr_q, skid_instr_d;
  logic [31:0]  skid_pc4_q, skid_pc4_d;

  logic         req_c;
  logic         ifid_load;
  logic [31:0]  ifid_instr_in;
  logic [31:0]  ifid_pc4_in;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    skid_valid_d  = skid_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc4_d    = skid_pc4_q;
    req_c         = 1'b0;
    ifid_load     = 1'b0;
    ifid_instr_in = imem.rdata;
    ifid_pc4_in   = req_addr_q + 32'd4;

    unique case (state_q)
      FETCH: begin
        if (redirect_valid_i) begin
          pc_d = word_align(redirect_pc_i);
        end else begin
          req_c      = 1'b1;
          req_addr_d = pc_q;
          pc_d       = pc_q + 32'd4;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid_i) begin
          pc_d    = word_align(redirect_pc_i);
          state_d = imem.rvalid ? FETCH : DISCARD;
        end else if (imem.rvalid) begin
          if (stall_i) begin
            skid_valid_d = 1'b1;
            skid_instr_d = imem.rdata;
            skid_pc4_d   = req_addr_q + 32'd4;
            state_d      = HOLD;
          end else begin
            ifid_load = 1'b1;
            state_d   = FETCH;
          end
        end
      end
      DISCARD: begin
        if (redirect_valid_i) pc_d = word_align(redirect_pc_i);
        if (imem.rvalid) state_d = FETCH;
      end
      HOLD: begin
        if (redirect_valid_i) begin
          skid_valid_d = 1'b0;
          pc_d         = word_align(redirect_pc_i);
          state_d      = FETCH;
        end else if (!stall_i) begin
          // A flushed skid entry drains as a bubble.
          ifid_load     = skid_valid_q;
          ifid_instr_in = skid_instr_q;
          ifid_pc4_in   = skid_pc4_q;
          skid_valid_d  = 1'b0;
          state_d       = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    if (flush_i) skid_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= word_align(RESET_PC);
      req_addr_q   <= 32'h0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc4_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  // state_q sits at FETCH during reset, so the request must be gated explicitly.
  assign imem.req  = req_c & rst_n;
  assign imem.addr = pc_q;

  ifid_reg u_ifid_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .stall_i (stall_i),
    .flush_i (flush_i),
    .load_i  (ifid_load),
    .instr_i (ifid_instr_in),
    .pc4_i   (ifid_pc4_in),
    .valid_o (ifid_valid_o),
    .instr_o (ifid_instr_o),
    .pc4_o   (ifid_pc4_o)
  );

  assign opcode_o = ifid_instr_o[OPCODE_MSB:OPCODE_LSB];
  assign funct_o  = ifid_instr_o[FUNCT_MSB:FUNCT_LSB];

  rvalid_only_when_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) imem.rvalid |-> (state_q inside {WAIT, DISCARD})
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations plus a random run
// checked every cycle against a transaction-level model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst_next;
  logic        stall, flush, redir;
  logic [31:0] redir_pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr, ifid_pc4;
  logic [5:0]  opcode, funct;

  logic        d2_valid;
  logic [31:0] d2_instr, d2_pc4;
  logic [5:0]  d2_opcode, d2_funct;

  int n_chk = 0;
  int n_err = 0;

  fetch_stage_if imem_bus ();
  fetch_stage_if bus2 ();

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem             (imem_bus),
    .stall_i          (stall),
    .flush_i          (flush),
    .redirect_valid_i (redir),
    .redirect_pc_i    (redir_pc),
    .ifid_valid_o     (ifid_valid),
    .ifid_instr_o     (ifid_instr),
    .ifid_pc4_o       (ifid_pc4),
    .opcode_o         (opcode),
    .funct_o          (funct)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem             (bus2),
    .stall_i          (1'b0),
    .flush_i          (1'b0),
    .redirect_valid_i (1'b0),
    .redirect_pc_i    (32'h0),
    .ifid_valid_o     (d2_valid),
    .ifid_instr_o     (d2_instr),
    .ifid_pc4_o       (d2_pc4),
    .opcode_o         (d2_opcode),
    .funct_o          (d2_funct)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[29:0], 2'b01} ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input logic s, input logic f, input logic r, input logic [31:0] p);
    @(posedge clk);
    #1;
    rst_n    = rst_next;
    stall    = s;
    flush    = f;
    redir    = r;
    redir_pc = p;
    @(negedge clk);
  endtask

  // Instruction memory for the main DUT: fixed or random latency of 1..3 cycles.
  int          mem_lat  = 1;
  bit          mem_rand = 1'b0;
  bit          mem_pend = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = 32'h0;

  initial begin
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      imem_bus.rvalid = 1'b0;
      if (mem_pend) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_bus.rvalid = 1'b1;
          imem_bus.rdata  = mem_word(mem_addr);
          mem_pend        = 1'b0;
        end
      end
      @(negedge clk);
      if (rst_n && imem_bus.req) begin
        chk("one_outstanding", {31'h0, mem_pend}, 32'h0);
        mem_pend = 1'b1;
        mem_addr = imem_bus.addr;
        mem_cnt  = mem_rand ? int'($urandom_range(1, 3)) : mem_lat;
      end
    end
  end

  // Latency-1 memory for the wrap-around instance; logs its first two requests.
  logic [31:0] log2[$];
  initial begin : mem2
    logic        p2;
    logic [31:0] a2;
    bus2.rvalid = 1'b0;
    bus2.rdata  = 32'h0;
    forever begin
      @(negedge clk);
      p2 = rst_n && bus2.req;
      a2 = bus2.addr;
      if (p2 && log2.size() < 2) log2.push_back(a2);
      @(posedge clk);
      #1;
      bus2.rvalid = p2;
      bus2.rdata  = mem_word(a2);
    end
  end

  // Transaction-level model of the main DUT.
  logic [31:0] m_pc, m_ra, m_i, m_p, m_skid_i, m_skid_p;
  bit          m_busy, m_drop, m_hold, m_skid_v, m_v;

  task automatic model_reset();
    m_pc = 32'h0; m_ra = 32'h0; m_busy = 0; m_drop = 0; m_hold = 0;
    m_skid_v = 0; m_skid_i = 32'h0; m_skid_p = 32'h0;
    m_v = 0; m_i = 32'h0; m_p = 32'h0;
  endtask

  task automatic model_step();
    bit          nv;
    logic [31:0] ni, np;
    nv = 0; ni = 32'h0; np = 32'h0;
    if (redir) begin
      m_pc = redir_pc & 32'hFFFF_FFFC;
      if (m_hold) begin
        m_hold = 0; m_skid_v = 0;
      end else if (m_busy) begin
        if (imem_bus.rvalid) begin m_busy = 0; m_drop = 0; end
        else m_drop = 1;
      end
    end else if (m_hold) begin
      if (!stall) begin
        nv = m_skid_v; ni = m_skid_i; np = m_skid_p; m_skid_v = 0; m_hold = 0;
      end
    end else if (!m_busy) begin
      m_ra = m_pc; m_pc = m_pc + 32'd4; m_busy = 1;
    end else if (imem_bus.rvalid) begin
      m_busy = 0;
      if (m_drop) m_drop = 0;
      else if (stall) begin
        m_skid_v = 1; m_skid_i = mem_word(m_ra); m_skid_p = m_ra + 32'd4; m_hold = 1;
      end else begin
        nv = 1; ni = mem_word(m_ra); np = m_ra + 32'd4;
      end
    end
    if (flush) begin
      m_v = 0; m_i = 32'h0; m_skid_v = 0;
    end else if (!stall) begin
      if (nv) begin m_v = 1; m_i = ni; m_p = np; end
      else begin m_v = 0; m_i = 32'h0; end
    end
  endtask

  initial begin : compare
    bit exp_req;
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      exp_req = rst_n && !m_busy && !m_hold && !redir;
      chk("m_req", {31'h0, imem_bus.req}, {31'h0, exp_req});
      if (exp_req) chk("m_addr", imem_bus.addr, m_pc);
      chk("m_valid", {31'h0, ifid_valid}, {31'h0, m_v});
      chk("m_instr", ifid_instr, m_i);
      if (m_v) chk("m_pc4", ifid_pc4, m_p);
      chk("m_opcode", {26'h0, opcode}, {26'h0, m_i[31:26]});
      chk("m_funct", {26'h0, funct}, {26'h0, m_i[5:0]});
      if (rst_n) model_step();
    end
  end

  initial begin : main
    rst_n = 1'b0; rst_next = 1'b0;
    stall = 1'b0; flush = 1'b0; redir = 1'b0; redir_pc = 32'h0;
    repeat (2) tick(0, 0, 0, 32'h0);
    chk("rst_req", {31'h0, imem_bus.req}, 32'h0);
    chk("rst_valid", {31'h0, ifid_valid}, 32'h0);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_pc4", ifid_pc4, 32'h0);

    // Sequential fetch at latency 1.
    rst_next = 1'b1;
    tick(0, 0, 0, 32'h0);                                   // C0
    chk("c0_req", {31'h0, imem_bus.req}, 32'h1);
    chk("c0_addr", imem_bus.addr, 32'h0);
    chk("d2_first_req", bus2.addr, 32'hFFFF_FFFC);
    tick(0, 0, 0, 32'h0);                                   // C1
    chk("c1_req", {31'h0, imem_bus.req}, 32'h0);
    tick(0, 0, 0, 32'h0);                                   // C2
    chk("c2_valid", {31'h0, ifid_valid}, 32'h1);
    chk("c2_pc4", ifid_pc4, 32'h4);
    chk("c2_instr", ifid_instr, 32'hC0DE_0001);
    chk("c2_addr", imem_bus.addr, 32'h4);
    chk("d2_pc4_wrap", d2_pc4, 32'h0);
    chk("d2_valid", {31'h0, d2_valid}, 32'h1);
    tick(0, 0, 0, 32'h0);                                   // C3
    chk("c3_bubble", {31'h0, ifid_valid}, 32'h0);
    tick(0, 0, 0, 32'h0);                                   // C4
    chk("c4_pc4", ifid_pc4, 32'h8);
    chk("c4_addr", imem_bus.addr, 32'h8);
    tick(0, 0, 0, 32'h0);                                   // C5

    // Stall for three cycles while the 0xC response arrives.
    tick(1, 0, 0, 32'h0);                                   // C6
    chk("c6_pc4", ifid_pc4, 32'hC);
    chk("c6_addr", imem_bus.addr, 32'hC);
    for (int c = 7; c <= 9; c++) begin
      tick((c < 9) ? 1'b1 : 1'b0, 0, 0, 32'h0);
      chk("stall_hold_pc4", ifid_pc4, 32'hC);
      chk("stall_hold_valid", {31'h0, ifid_valid}, 32'h1);
      chk("stall_no_req", {31'h0, imem_bus.req}, 32'h0);
    end
    mem_lat = 2;
    tick(0, 0, 0, 32'h0);                                   // C10
    chk("skid_pc4", ifid_pc4, 32'h10);
    chk("skid_valid", {31'h0, ifid_valid}, 32'h1);
    chk("c10_addr", imem_bus.addr, 32'h10);

    // Redirect in WAIT; the late response is discarded.
    tick(0, 0, 1, 32'h100);                                 // C11
    tick(0, 0, 0, 32'h0);                                   // C12
    chk("discard_no_req", {31'h0, imem_bus.req}, 32'h0);
    tick(0, 0, 0, 32'h0);                                   // C13
    chk("redir_req", {31'h0, imem_bus.req}, 32'h1);
    chk("redir_addr", imem_bus.addr, 32'h100);
    tick(0, 0, 0, 32'h0);                                   // C14
    tick(0, 0, 0, 32'h0);                                   // C15
    mem_lat = 3;

    // Flush together with redirect while IF/ID holds the 0x100 instruction.
    tick(0, 1, 1, 32'h40);                                  // C16
    chk("redir_pc4", ifid_pc4, 32'h104);
    chk("redir_instr", ifid_instr, mem_word(32'h100));
    tick(0, 0, 0, 32'h0);                                   // C17
    chk("flush_valid", {31'h0, ifid_valid}, 32'h0);
    chk("flush_opcode", {26'h0, opcode}, 32'h0);
    chk("flush_addr", imem_bus.addr, 32'h40);

    // Reset while a request is outstanding.
    rst_next = 1'b0;
    tick(0, 0, 0, 32'h0);                                   // C18
    chk("wrst_req", {31'h0, imem_bus.req}, 32'h0);
    chk("wrst_valid", {31'h0, ifid_valid}, 32'h0);
    chk("wrst_instr", ifid_instr, 32'h0);
    repeat (3) tick(0, 0, 0, 32'h0);
    mem_lat  = 1;
    rst_next = 1'b1;
    tick(0, 0, 0, 32'h0);
    chk("post_rst_req", {31'h0, imem_bus.req}, 32'h1);
    chk("post_rst_addr", imem_bus.addr, 32'h0);

    chk("d2_log_size", log2.size(), 32'd2);
    if (log2.size() == 2) begin
      chk("d2_req0", log2[0], 32'hFFFF_FFFC);
      chk("d2_req1", log2[1], 32'h0);
    end

    // Random traffic against the model.
    mem_rand = 1'b1;
    repeat (3000) begin
      tick(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 7) == 0), $urandom);
    end
    tick(0, 0, 0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
